// File: rtl/useq_pkg.sv
// Shared types and constants for the microprogram sequencer: state encoding,
// next-address select codes and the position of the branch field in a control word.
package useq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        ERR   = 2'b11
    } useq_state_t;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_NEXT = 2'b10;
    localparam logic [1:0] SEL_RET  = 2'b11;

    localparam int CW_BR_LSB = 16;

endpackage

// File: rtl/useq_ret_stack.sv
// Return-address storage for micro-calls. With RET_STACK_EN defined it is a
// STACK_DEPTH-entry LIFO; otherwise a single link register with a valid bit.
module useq_ret_stack #(
    parameter int ADDR_W = 8
`ifdef RET_STACK_EN
  , parameter int STACK_DEPTH = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

`ifdef RET_STACK_EN
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] entries [STACK_DEPTH];
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  top_idx;

    assign full    = (count == CNT_W'(STACK_DEPTH));
    assign empty   = (count == '0);
    assign top_idx = PTR_W'(count - CNT_W'(1));
    assign top     = entries[top_idx];

    // Overflowing pushes and underflowing pops are refused here; the caller flags them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            entries[PTR_W'(count)] <= push_addr;
            count                  <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end
`else
    logic [ADDR_W-1:0] link;
    logic              link_valid;

    assign full  = 1'b0;
    assign empty = ~link_valid;
    assign top   = link;

    // A push simply overwrites the link; a pop consumes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            link_valid <= 1'b0;
        end else if (push) begin
            link       <= push_addr;
            link_valid <= 1'b1;
        end else if (pop) begin
            link_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/useq_fetch.sv
// Micro-PC sequencer and control-store fetch stage feeding the CW decoder.
// Return stack style is selected by RET_STACK_EN (LIFO) vs. link register (default).
module useq_fetch
    import useq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] instr_start_addr,
    output logic              instr_ready,
    input  logic              S0,
    input  logic              S1,
    input  logic              call_push,
    input  logic              ret_pop,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_waddr,
    input  logic [31:0]       cs_wdata,
    output logic [31:0]       CW,
    output logic              cw_valid,
    output logic [ADDR_W-1:0] upc,
    output logic              stack_err
);

    if (ADDR_W > 16 || STACK_DEPTH < 1) begin : g_param_check
        $error("useq_fetch: branch field holds at most 16 address bits and the stack needs an entry");
    end

    useq_state_t       state, state_nxt;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] start_q, rd_addr, ret_addr, stk_top;
    logic              rd_en, hs, push, pop, err_set, stk_full, stk_empty;
    logic [31:0]       cs_mem [2**ADDR_W];

    assign sel         = {S1, S0};
    assign ret_addr    = upc + ADDR_W'(1);
    assign instr_ready = rst_n & (state == IDLE) & ~cs_we;
    assign hs          = instr_valid & instr_ready;

    useq_ret_stack #(
        .ADDR_W     (ADDR_W)
`ifdef RET_STACK_EN
      , .STACK_DEPTH(STACK_DEPTH)
`endif
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_addr(ret_addr),
        .full     (stk_full),
        .empty    (stk_empty),
        .top      (stk_top)
    );

    // Next-state and read-address selection; a read issued here lands in CW next edge.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = start_q;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE:  if (hs) state_nxt = FETCH;
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                rd_en   = 1'b1;
                rd_addr = ret_addr;
                case (sel)
                    SEL_BR: begin
                        rd_addr = CW[CW_BR_LSB +: ADDR_W];
                        if (call_push) begin
                            if (stk_full) err_set = 1'b1;
                            else          push    = 1'b1;
                        end
                    end
                    SEL_NEXT: begin
                        rd_en     = 1'b0;
                        state_nxt = IDLE;
                    end
                    SEL_RET: begin
                        if (ret_pop) begin
                            if (stk_empty) begin
                                err_set = 1'b1;
                            end else begin
                                pop     = 1'b1;
                                rd_addr = stk_top;
                            end
                        end
                    end
                    default: ;
                endcase
                if (err_set) begin
                    rd_en     = 1'b0;
                    state_nxt = ERR;
                end
            end
            default: ;
        endcase
    end

    // Writes are only accepted while idle, so they never collide with a fetch.
    always_ff @(posedge clk) begin
        if (state == IDLE && cs_we)
            cs_mem[cs_waddr] <= cs_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= '0;
            upc       <= '0;
            CW        <= '0;
            cw_valid  <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cw_valid <= rd_en;
            if (hs)
                start_q <= instr_start_addr;
            if (rd_en) begin
                CW  <= cs_mem[rd_addr];
                upc <= rd_addr;
            end
            if (err_set)
                stack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_useq_fetch.sv
// Self-checking bench for useq_fetch: the bench plays the decoder, expected CWs
// come from a scoreboard queue. Covers both RET_STACK_EN settings.
module tb_useq_fetch;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, NXT = 2'b10, RET = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic [ADDR_W-1:0] instr_start_addr = '0;
    logic              instr_ready;
    logic              S0 = 1'b0, S1 = 1'b0, call_push = 1'b0, ret_pop = 1'b0;
    logic              cs_we = 1'b0;
    logic [ADDR_W-1:0] cs_waddr = '0;
    logic [31:0]       cs_wdata = '0;
    logic [31:0]       CW;
    logic              cw_valid;
    logic [ADDR_W-1:0] upc;
    logic              stack_err;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cs_model [256];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    useq_fetch #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_start_addr(instr_start_addr), .instr_ready(instr_ready),
        .S0(S0), .S1(S1), .call_push(call_push), .ret_pop(ret_pop),
        .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
        .CW(CW), .cw_valid(cw_valid), .upc(upc), .stack_err(stack_err)
    );

    // CW layout used by the bench: [31:24] tag, [23:16] target, [3] ret, [2] call, [1:0] sel
    function automatic logic [31:0] mk(input logic [7:0] tag, input logic [1:0] sel,
                                       input logic call, input logic ret, input logic [7:0] tgt);
        return {tag, tgt, 12'h000, ret, call, sel};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: sample just after the edge, score any live CW, then decode it.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (cw_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("sb_extra_cw", 32'(cw_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("cw@%0h", e.addr), CW, e.word);
                checkOutput($sformatf("upc@%0h", e.addr), 32'(upc), 32'(e.addr));
            end
            {S1, S0}  = CW[1:0];
            call_push = CW[2];
            ret_pop   = CW[3];
        end else begin
            {S1, S0}  = 2'b00;
            call_push = 1'b0;
            ret_pop   = 1'b0;
        end
    endtask

    task automatic write_word(input logic [7:0] addr, input logic [31:0] data);
        cs_we          = 1'b1;
        cs_waddr       = addr;
        cs_wdata       = data;
        cs_model[addr] = data;
        step();
        cs_we = 1'b0;
    endtask

    task automatic expect_cw(input logic [7:0] addr);
        sb.push_back('{addr, cs_model[addr]});
    endtask

    task automatic applyStimulus(input logic [7:0] start);
        int n = 0;
        instr_valid      = 1'b1;
        instr_start_addr = start;
        #1;
        while (instr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput("hs_ready", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
    endtask

    task automatic run_to_idle(input string tag);
        int n = 0;
        while (!(cw_valid === 1'b0 && instr_ready === 1'b1) && n < 40) begin
            step();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(instr_ready), 32'd1);
        checkOutput({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_err_and_reset(input string tag);
        checkOutput({tag, "_err"}, 32'(stack_err), 32'd1);
        checkOutput({tag, "_cwv"}, 32'(cw_valid), 32'd0);
        instr_valid = 1'b1;
        #1;
        checkOutput({tag, "_rdy"}, 32'(instr_ready), 32'd0);
        step();
        checkOutput({tag, "_sticky"}, 32'(stack_err), 32'd1);
        checkOutput({tag, "_cwv_hold"}, 32'(cw_valid), 32'd0);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput({tag, "_err_clr"}, 32'(stack_err), 32'd0);
        #1;
        checkOutput({tag, "_rdy_back"}, 32'(instr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, with instr_valid held high to show instr_ready is forced low.
        instr_valid = 1'b1;
        step();
        step();
        checkOutput("rst_cwv", 32'(cw_valid), 32'd0);
        checkOutput("rst_upc", 32'(upc), 32'd0);
        checkOutput("rst_cw", CW, 32'd0);
        checkOutput("rst_err", 32'(stack_err), 32'd0);
        checkOutput("rst_rdy", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("rdy_after_rst", 32'(instr_ready), 32'd1);

        // Load microprograms.
        write_word(8'h10, mk(8'h10, SEQ, 1'b0, 1'b0, 8'h00));
        write_word(8'h11, mk(8'h11, SEQ, 1'b0, 1'b0, 8'h00));
        write_word(8'h12, mk(8'h12, NXT, 1'b0, 1'b0, 8'h00));
        write_word(8'h20, mk(8'h20, BR,  1'b1, 1'b0, 8'h40));
        write_word(8'h21, mk(8'h21, NXT, 1'b0, 1'b0, 8'h00));
        write_word(8'h40, mk(8'h40, RET, 1'b0, 1'b1, 8'h00));
        write_word(8'h70, mk(8'h70, RET, 1'b0, 1'b0, 8'h33));
        write_word(8'h71, mk(8'h71, NXT, 1'b0, 1'b0, 8'h00));
        write_word(8'hFF, mk(8'hFF, SEQ, 1'b0, 1'b0, 8'h00));
        write_word(8'h00, mk(8'h00, NXT, 1'b0, 1'b0, 8'h00));
        write_word(8'h50, mk(8'h50, SEQ, 1'b0, 1'b0, 8'h00));
        write_word(8'h51, mk(8'h51, SEQ, 1'b0, 1'b0, 8'h00));
        write_word(8'h60, mk(8'h60, RET, 1'b0, 1'b1, 8'h00));
`ifdef RET_STACK_EN
        for (int i = 0; i < 5; i++)
            write_word(8'(8'h80 + i), mk(8'(8'h80 + i), BR, 1'b1, 1'b0, 8'(8'h81 + i)));
        write_word(8'h85, mk(8'h85, NXT, 1'b0, 1'b0, 8'h00));
`else
        write_word(8'h90, mk(8'h90, BR,  1'b1, 1'b0, 8'hA0));
        write_word(8'hA0, mk(8'hA0, BR,  1'b1, 1'b0, 8'hB0));
        write_word(8'hB0, mk(8'hB0, RET, 1'b0, 1'b1, 8'h00));
        write_word(8'hA1, mk(8'hA1, RET, 1'b0, 1'b1, 8'h00));
`endif

        // Sequential run with explicit latency and return-to-idle timing.
        expect_cw(8'h10); expect_cw(8'h11); expect_cw(8'h12);
        applyStimulus(8'h10);
        checkOutput("fetch_gap", 32'(cw_valid), 32'd0);
        step();
        step();
        step();
        step();
        checkOutput("seq_idle_cwv", 32'(cw_valid), 32'd0);
        checkOutput("seq_idle_rdy", 32'(instr_ready), 32'd1);
        checkOutput("seq_drained", 32'(sb.size()), 32'd0);

        // Call and return.
        expect_cw(8'h20); expect_cw(8'h40); expect_cw(8'h21);
        applyStimulus(8'h20);
        run_to_idle("call");

        // sel=11 without ret_pop behaves as sequential.
        expect_cw(8'h70); expect_cw(8'h71);
        applyStimulus(8'h70);
        run_to_idle("ret_nopop");

        // Micro-PC wraps from the top of the store.
        expect_cw(8'hFF); expect_cw(8'h00);
        applyStimulus(8'hFF);
        run_to_idle("wrap");

        // Write and handshake offered together: write wins, handshake next cycle.
        cs_we = 1'b1; cs_waddr = 8'h30; cs_wdata = mk(8'h30, NXT, 1'b0, 1'b0, 8'h5A);
        cs_model[8'h30] = cs_wdata;
        instr_valid = 1'b1; instr_start_addr = 8'h30;
        #1;
        checkOutput("we_blocks_rdy", 32'(instr_ready), 32'd0);
        step();
        cs_we = 1'b0;
        #1;
        checkOutput("rdy_after_we", 32'(instr_ready), 32'd1);
        expect_cw(8'h30);
        step();
        instr_valid = 1'b0;
        checkOutput("coll_fetch_gap", 32'(cw_valid), 32'd0);
        run_to_idle("collide");

        // Reset in the middle of EXEC.
        expect_cw(8'h50);
        applyStimulus(8'h50);
        step();
        rst_n = 1'b0;
        step();
        checkOutput("midrst_cwv", 32'(cw_valid), 32'd0);
        checkOutput("midrst_upc", 32'(upc), 32'd0);
        checkOutput("midrst_cw", CW, 32'd0);
        rst_n = 1'b1;
        checkOutput("midrst_drained", 32'(sb.size()), 32'd0);

        // Return with nothing stacked.
        expect_cw(8'h60);
        applyStimulus(8'h60);
        step();
        step();
        check_err_and_reset("underflow");

`ifdef RET_STACK_EN
        // Fifth nested call overflows a four-deep stack.
        for (int i = 0; i < 5; i++) expect_cw(8'(8'h80 + i));
        applyStimulus(8'h80);
        for (int i = 0; i < 6; i++) step();
        check_err_and_reset("overflow");
`else
        // Second call overwrites the link; the second return then finds it empty.
        expect_cw(8'h90); expect_cw(8'hA0); expect_cw(8'hB0); expect_cw(8'hA1);
        applyStimulus(8'h90);
        for (int i = 0; i < 5; i++) step();
        check_err_and_reset("link_reuse");
`endif
        checkOutput("final_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
